instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the main decoder: holds the PC, requests instruction words over a
//  req/gnt/rvalid bus and presents instr + instr_valid to the decoder/datapath. Computes the next PC
//  from the decoder's jump/branch outputs and the ALU zero flag when an instruction retires.
//  Also counts retired instructions and flags a fetch timeout.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; must be word aligned
//  TIMEOUT    16             max cycles in WAIT before fetch_err (>=2)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  imem_req     out  1   fetch request, held until imem_gnt
//  imem_addr    out  32  fetch address (= pc), bits [1:0] always 00
//  imem_gnt     in   1   request accepted this cycle
//  imem_rvalid  in   1   imem_rdata valid (earliest the cycle after gnt)
//  imem_rdata   in   32  instruction word
//  instr        out  32  current instruction to decoder
//  instr_valid  out  1   instr/pc valid
//  instr_ready  in   1   core executes instr this cycle (retire)
//  jump         in   1   from decoder, sampled on retire
//  branch       in   1   from decoder, sampled on retire
//  zero         in   1   ALU zero, sampled on retire
//  pc           out  32  address of instr
//  pc_plus4     out  32  pc + 4 (mod 2^32)
//  instr_count  out  32  retired instructions, wraps
//  fetch_err    out  1   sticky timeout flag
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, instr=0 (nop), instr_valid=0, fetch_err=0,
//   instr_count=0, timeout counter=0. imem_req=0 while rst=1. Reset overrides all, in any state.
//  FSM: IDLE -> REQ unconditionally (one cycle after reset release).
//   REQ:   imem_req=1, imem_addr=pc; on imem_gnt -> WAIT, clear counter.
//   WAIT:  counter++ each cycle; on imem_rvalid: instr<=imem_rdata -> VALID; else if counter
//          reaches TIMEOUT-1 -> ERR. rvalid takes priority over timeout in the same cycle.
//   VALID: instr_valid=1; instr, pc stable while instr_ready=0 (stall any length).
//          On instr_ready: pc<=next_pc, instr_count++, -> REQ.
//   ERR:   fetch_err=1, imem_req=0, instr_valid=0; exit only by rst.
//  imem_rvalid outside WAIT and imem_gnt outside REQ are ignored. Memory is reset by the same rst;
//   no stale rvalid after reset is expected or tolerated.
//  next_pc (combinational, from current pc/instr):
//   jump=1                -> {pc_plus4[31:28], instr[25:0], 2'b00}   (jump beats branch)
//   branch=1 & zero=1     -> pc_plus4 + (sext(instr[15:0]) << 2), mod 2^32
//   otherwise             -> pc_plus4; 0xFFFF_FFFC wraps to 0x0000_0000
//  Min latency: REQ->gnt same cycle, rvalid next cycle => instr_valid 2 cycles after REQ entry.
//  Throughput max one retire per 3 cycles (no prefetch).
//  instr_count 0xFFFF_FFFF + retire -> 0.
//  All outputs are driven from registers or a decode of the registered state; no comb path from
//  instr_ready to imem_req.
// STRUCTURE
//  mips_pkg: opcode constants OP_RTYPE 6'h00, OP_LW 6'h23, OP_SW 6'h2B, OP_ADDI 6'h08,
//   OP_BEQ 6'h04, OP_J 6'h02; fetch state encoding (IDLE, REQ, WAIT, VALID, ERR); NOP word.
//  Sub-module pc_next_logic: combinational next_pc/pc_plus4 from pc, instr, jump, branch, zero.
//  Top holds FSM, pc/instr/count registers, timeout counter.
// TESTING
//  1 Reset release, gnt immediately, rvalid 2 cycles later data 0x2008_0005 -> imem_addr=0x0,
//    instr_valid=1, instr=0x2008_0005, pc=0x0, pc_plus4=0x4.
//  2 Retire with jump=0,branch=0 after 5-cycle stall -> instr/pc stable during stall; next
//    imem_addr=0x4, instr_count=1.
//  3 pc=0x10, instr=0x1000_FFFC, branch=1: zero=1 -> next addr 0x04; zero=0 -> 0x14.
//  4 pc=0x0040_0008, instr=0x0810_0010, jump=1, branch=1, zero=1 -> next addr 0x0040_0040.
//  5 TIMEOUT=16, gnt then no rvalid 16 cycles -> fetch_err=1, imem_req=0 and instr_valid=0
//    held until rst; late rvalid ignored.
//  6 rst pulsed during WAIT with pc=0x20 -> next cycle pc=RESET_PC, instr_valid=0, instr=0,
//    instr_count=0; fetch restarts at RESET_PC via IDLE->REQ.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants for the fetch stage. Holds the MIPS opcode
//               values, the fetch FSM state encoding, the NOP word and a
//               helper that forms the branch byte offset.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_ERR   = 3'd4
  } fetch_state_e;

  // Sign-extended 16-bit word offset converted to a byte offset
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_pc_next_logic.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_logic
// Description : Combinational next-PC computation. Jump overrides a taken
//               branch; otherwise the sequential PC is used. All arithmetic
//               wraps modulo 2^32.
// Ports       : pc        in  32  current (word aligned) PC
//               instr_idx in  26  low 26 bits of the current instruction
//               jump      in   1  decoder jump
//               branch    in   1  decoder branch
//               zero      in   1  ALU zero flag
//               pc_plus4  out 32  pc + 4
//               next_pc   out 32  PC to load on retire
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_logic
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      // Pseudo-direct: region bits come from the delay-slot address
      next_pc = {pc_plus4[31:28], instr_idx, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset(instr_idx[15:0]);
    end
  end

endmodule : pc_next_logic
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Non-prefetching fetch stage. Requests one word at a time over
//               a req/gnt/rvalid bus, presents it to the decoder, and on
//               retire advances the PC using jump/branch/zero. Counts retired
//               instructions and enters a sticky error state when a granted
//               fetch gets no data within TIMEOUT cycles.
// Ports       : clk, rst                      clock, sync active-high reset
//               imem_req/addr (out)           fetch request and address
//               imem_gnt/rvalid/rdata (in)    bus response
//               instr/instr_valid (out)       word to decoder
//               instr_ready (in)              retire strobe
//               jump/branch/zero (in)         next-PC controls on retire
//               pc/pc_plus4 (out)             address of instr and +4
//               instr_count (out)             retired count, wraps
//               fetch_err (out)               sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count,
  output logic        fetch_err
);

  localparam int             CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  // Low address bits forced to zero so the bus address is always aligned
  localparam logic [31:0]    PC_INIT  = {RESET_PC[31:2], 2'b00};

  fetch_state_e     state_q;
  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic [31:0]      count_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [31:0]      next_pc;

  pc_next_logic u_pc_next (
    .pc        (pc_q),
    .instr_idx (instr_q[25:0]),
    .jump      (jump),
    .branch    (branch),
    .zero      (zero),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= PC_INIT;
      instr_q   <= NOP_WORD;
      count_q   <= '0;
      tmo_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_q <= ST_REQ;
        ST_REQ: begin
          if (imem_gnt) begin
            state_q   <= ST_WAIT;
            tmo_cnt_q <= '0;
          end
        end
        ST_WAIT: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          // Data arriving on the last allowed cycle still wins
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            state_q <= ST_VALID;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q <= ST_ERR;
          end
        end
        ST_VALID: begin
          if (instr_ready) begin
            pc_q    <= next_pc;
            count_q <= count_q + 32'd1;
            state_q <= ST_REQ;
          end
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request is masked during reset so the bus sees no request before the
  // FSM has returned to IDLE.
  assign imem_req    = (state_q == ST_REQ) && !rst;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_VALID);
  assign pc          = pc_q;
  assign instr_count = count_q;
  assign fetch_err   = (state_q == ST_ERR);

endmodule : instr_fetch_unit
`default_nettype wire
